// File: rtl/blink_seq_pkg.sv
// ---------------------------------------------------------------------------
// blink_seq_pkg
//   Shared definitions for the blinking-light run/pause/stop sequencer.
//   - blink_state_t : FSM state encoding (also driven out on the state port)
//   - SEL_A / SEL_B : pattern-select levels seen by the LED datapath
//   - phase_sel     : pattern-select level belonging to a RUN phase
//   - other_phase   : the RUN phase entered at a DWELL boundary
// ---------------------------------------------------------------------------
package blink_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_A = 2'd1,
        ST_RUN_B = 2'd2,
        ST_PAUSE = 2'd3
    } blink_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    function automatic logic phase_sel(input blink_state_t ph);
        return (ph == ST_RUN_B) ? SEL_B : SEL_A;
    endfunction

    function automatic blink_state_t other_phase(input blink_state_t ph);
        return (ph == ST_RUN_A) ? ST_RUN_B : ST_RUN_A;
    endfunction

endpackage

// File: rtl/blink_seq_ctrl_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to the datapath step rate. The counter runs
//   0..PRESCALE-1 while run is high, holds while run is low, and is forced
//   to zero by clr (clr has priority over run).
// Ports
//   clk   in  1  system clock, rising edge
//   reset in  1  asynchronous, active-high
//   run   in  1  count enable
//   clr   in  1  synchronous clear
//   tick  out 1  high for the one cycle the counter sits at PRESCALE-1
//                while running (decoded from the count register)
// ---------------------------------------------------------------------------
module tick_prescaler
    import blink_seq_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int           W    = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && w_at_last;

endmodule

// File: rtl/blink_seq_ctrl.sv
// ---------------------------------------------------------------------------
// blink_seq_ctrl
//   Run/pause/stop sequencer for the 16-LED blinking-light datapath.
//   Produces the datapath step strobe from a prescaled clock and flips the
//   pattern select every DWELL steps.
// Parameters
//   PRESCALE  clk cycles per datapath step (>= 2)
//   DWELL     steps per pattern before sel toggles (2..2**CNT_W)
//   CNT_W     width of step_cnt
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      IDLE->RUN_A, or resume from PAUSE
//   stop      in   1      RUN->PAUSE, or PAUSE->IDLE (wins over start)
//   step_en   out  1      one-cycle strobe: datapath advances this cycle
//   sel       out  1      pattern select (1 = pattern A, 0 = pattern B)
//   step_cnt  out  CNT_W  steps taken in the current pattern
//   state     out  2      FSM state (IDLE=0, RUN_A=1, RUN_B=2, PAUSE=3)
//   busy      out  1      high in RUN_A / RUN_B
// Build option
//   BLINK_SEQ_BTN_SYNC_EN : start/stop go through 2-flop synchronisers and
//   a rising-edge detector (raw button levels, +2 cycles latency, one action
//   per press). Undefined: start/stop are used directly as sync pulses.
// ---------------------------------------------------------------------------
module blink_seq_ctrl
    import blink_seq_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DWELL    = 65536,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             step_en,
    output logic             sel,
    output logic [CNT_W-1:0] step_cnt,
    output logic [1:0]       state,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DWELL - 1);

    logic             w_start;
    logic             w_stop;
    logic             w_tick;
    logic             w_pre_clr;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_after;
    blink_state_t     w_phase_after;

    blink_state_t     r_state;
    blink_state_t     r_saved_phase;
    logic             r_sel;
    logic             r_busy;
    logic [CNT_W-1:0] r_step_cnt;

    // -----------------------------------------------------------------------
    // Button conditioning
    // -----------------------------------------------------------------------
`ifdef BLINK_SEQ_BTN_SYNC_EN
    logic [1:0] r_start_sync;
    logic [1:0] r_stop_sync;
    logic       r_start_prev;
    logic       r_stop_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], start};
            r_stop_sync  <= {r_stop_sync[0], stop};
            r_start_prev <= r_start_sync[1];
            r_stop_prev  <= r_stop_sync[1];
        end
    end

    assign w_start = r_start_sync[1] && !r_start_prev;
    assign w_stop  = r_stop_sync[1]  && !r_stop_prev;
`else
    assign w_start = start;
    assign w_stop  = stop;
`endif

    // -----------------------------------------------------------------------
    // Step-rate prescaler: runs only while busy, holds through PAUSE.
    // Clearing on PAUSE+stop (not just while in IDLE) keeps the count at
    // zero from the very first IDLE cycle.
    // -----------------------------------------------------------------------
    assign w_pre_clr = (r_state == ST_IDLE) || ((r_state == ST_PAUSE) && w_stop);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (r_busy),
        .clr   (w_pre_clr),
        .tick  (w_tick)
    );

    // -----------------------------------------------------------------------
    // Post-step phase and count. Computed unconditionally so that a stop
    // landing on a step edge still takes the step and PAUSE records the
    // phase as it stands after that step.
    // -----------------------------------------------------------------------
    assign w_last = (r_step_cnt == LAST_STEP);

    always_comb begin
        w_cnt_after   = r_step_cnt;
        w_phase_after = r_state;
        if (w_tick) begin
            if (w_last) begin
                w_cnt_after   = '0;
                w_phase_after = other_phase(r_state);
            end else begin
                w_cnt_after   = r_step_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered sel / busy / step_cnt
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_saved_phase <= ST_RUN_A;
            r_sel         <= SEL_A;
            r_busy        <= 1'b0;
            r_step_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // stop wins over a simultaneous start; stop alone is ignored
                    if (w_start && !w_stop) begin
                        r_state    <= ST_RUN_A;
                        r_sel      <= SEL_A;
                        r_busy     <= 1'b1;
                        r_step_cnt <= '0;
                    end
                end
                ST_RUN_A, ST_RUN_B: begin
                    r_step_cnt <= w_cnt_after;
                    r_sel      <= phase_sel(w_phase_after);
                    if (w_stop) begin
                        r_state       <= ST_PAUSE;
                        r_saved_phase <= w_phase_after;
                        r_busy        <= 1'b0;
                    end else begin
                        r_state       <= w_phase_after;
                    end
                end
                ST_PAUSE: begin
                    if (w_stop) begin
                        r_state       <= ST_IDLE;
                        r_saved_phase <= ST_RUN_A;
                        r_sel         <= SEL_A;
                        r_step_cnt    <= '0;
                    end else if (w_start) begin
                        r_state <= r_saved_phase;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign step_en  = w_tick;
    assign sel      = r_sel;
    assign step_cnt = r_step_cnt;
    assign state    = r_state;
    assign busy     = r_busy;

endmodule
